// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller and access arbiter for the two-bank, eight-lane SRAM core.
// Passes functional accesses through when idle; owns the core while a test runs.
module sram_bist_ctrl #(
    parameter int          TEST_AW = 13,
    parameter logic [31:0] BG      = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        hrst,
    input  logic        bist_start,
    output logic        bist_busy,
    output logic        bist_done,
    output logic        bist_fail,
    output logic [1:0]  fail_bank,
    output logic [12:0] fail_addr,
    input  logic [3:0]  f_bank0_csn,
    input  logic [3:0]  f_bank1_csn,
    input  logic        f_sram_we,
    input  logic [12:0] f_sram_addr,
    input  logic [31:0] f_sram_wdata,
    output logic [3:0]  bank0_csn,
    output logic [3:0]  bank1_csn,
    output logic        sram_we,
    output logic [12:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [7:0]  sram_q0,
    input  logic [7:0]  sram_q1,
    input  logic [7:0]  sram_q2,
    input  logic [7:0]  sram_q3,
    input  logic [7:0]  sram_q4,
    input  logic [7:0]  sram_q5,
    input  logic [7:0]  sram_q6,
    input  logic [7:0]  sram_q7
);

    typedef enum logic [3:0] {
        IDLE, M0, M1_R, M1_W, M2_R, M2_W, M3_R, M3_W, M4_R, M4_W, M5, DRAIN
    } state_t;

    localparam logic [TEST_AW-1:0] ADDR_LAST = '1;
    localparam logic [TEST_AW-1:0] ADDR_ZERO = '0;
    localparam logic [TEST_AW-1:0] ADDR_ONE  = TEST_AW'(1);

    function automatic logic st_is_read(input state_t s);
        return (s == M1_R) || (s == M2_R) || (s == M3_R) || (s == M4_R) || (s == M5);
    endfunction

    function automatic logic st_is_write(input state_t s);
        return (s == M0) || (s == M1_W) || (s == M2_W) || (s == M3_W) || (s == M4_W);
    endfunction

    function automatic logic [31:0] st_exp_word(input state_t s);
        return ((s == M2_R) || (s == M4_R)) ? ~BG : BG;
    endfunction

    function automatic logic [31:0] st_wr_word(input state_t s);
        return ((s == M1_W) || (s == M3_W)) ? ~BG : BG;
    endfunction

    state_t             state_q, state_d;
    logic [TEST_AW-1:0] addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [1:0]         fbank_q, fbank_d;
    logic [12:0]        faddr_q, faddr_d;
    logic               exp_valid_q, exp_valid_d;
    logic [31:0]        exp_word_q, exp_word_d;
    logic [TEST_AW-1:0] exp_addr_q, exp_addr_d;

    logic [31:0] rd0, rd1;
    logic        mis0, mis1;
    logic [12:0] exp_addr_ext;
    logic [12:0] bist_addr;
    logic [3:0]  bist_csn;
    logic        bist_we;
    logic [31:0] bist_wdata;

    // Stage boundary: read data from the previous cycle checked against the registered expectation
    always_comb begin
        rd0  = {sram_q3, sram_q2, sram_q1, sram_q0};
        rd1  = {sram_q7, sram_q6, sram_q5, sram_q4};
        mis0 = exp_valid_q && (rd0 != exp_word_q);
        mis1 = exp_valid_q && (rd1 != exp_word_q);
        exp_addr_ext = '0;
        exp_addr_ext[TEST_AW-1:0] = exp_addr_q;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fbank_d     = fbank_q;
        faddr_d     = faddr_q;
        exp_valid_d = st_is_read(state_q);
        exp_word_d  = st_exp_word(state_q);
        exp_addr_d  = addr_q;

        // Only the first mismatching address is recorded; the test always runs to the end.
        if ((mis0 || mis1) && !fail_q) begin
            fail_d  = 1'b1;
            fbank_d = {mis1, mis0};
            faddr_d = exp_addr_ext;
        end

        case (state_q)
            IDLE: begin
                if (bist_start) begin
                    state_d = M0;
                    addr_d  = ADDR_ZERO;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    fbank_d = 2'b00;
                    faddr_d = '0;
                end
            end
            M0: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = M1_R;
                    addr_d  = ADDR_ZERO;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            M1_R: state_d = M1_W;
            M1_W: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = M2_R;
                    addr_d  = ADDR_ZERO;
                end else begin
                    state_d = M1_R;
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
            M2_R: state_d = M2_W;
            M2_W: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = M3_R;
                    addr_d  = ADDR_LAST;
                end else begin
                    state_d = M2_R;
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
            M3_R: state_d = M3_W;
            M3_W: begin
                if (addr_q == ADDR_ZERO) begin
                    state_d = M4_R;
                    addr_d  = ADDR_LAST;
                end else begin
                    state_d = M3_R;
                    addr_d  = addr_q - ADDR_ONE;
                end
            end
            M4_R: state_d = M4_W;
            M4_W: begin
                if (addr_q == ADDR_ZERO) begin
                    state_d = M5;
                    addr_d  = ADDR_ZERO;
                end else begin
                    state_d = M4_R;
                    addr_d  = addr_q - ADDR_ONE;
                end
            end
            M5: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = DRAIN;
                    addr_d  = ADDR_ZERO;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                addr_d  = ADDR_ZERO;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                addr_d  = ADDR_ZERO;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q     <= IDLE;
            addr_q      <= ADDR_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fbank_q     <= 2'b00;
            faddr_q     <= '0;
            exp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fbank_q     <= fbank_d;
            faddr_q     <= faddr_d;
            exp_valid_q <= exp_valid_d;
        end
    end

    // Expectation data is qualified by exp_valid_q, so it needs no reset.
    always_ff @(posedge hclk) begin
        exp_word_q <= exp_word_d;
        exp_addr_q <= exp_addr_d;
    end

    always_comb begin
        bist_addr = '0;
        bist_addr[TEST_AW-1:0] = addr_q;
        bist_we    = st_is_write(state_q);
        bist_csn   = (st_is_read(state_q) || st_is_write(state_q)) ? 4'h0 : 4'hF;
        bist_wdata = st_wr_word(state_q);
    end

    always_comb begin
        bank0_csn  = f_bank0_csn;
        bank1_csn  = f_bank1_csn;
        sram_we    = f_sram_we;
        sram_addr  = f_sram_addr;
        sram_wdata = f_sram_wdata;
        if (busy_q) begin
            bank0_csn  = bist_csn;
            bank1_csn  = bist_csn;
            sram_we    = bist_we;
            sram_addr  = bist_addr;
            sram_wdata = bist_wdata;
        end
    end

    assign bist_busy = busy_q;
    assign bist_done = done_q;
    assign bist_fail = fail_q;
    assign fail_bank = fbank_q;
    assign fail_addr = faddr_q;

endmodule
